vector_max_feeder: RTL and testbench
====================================

Name: vector_max_feeder

Overview:
- Producer side of the vector_max start/done interface.
- Accepts a scalar stream over valid/ready and packs 4 scalars into one 4-lane vector.
- Pulses start to the downstream max unit, then waits for its done and captures max_in.
- Presents the captured result on a valid/ready output, and flags a watchdog error if done never arrives.

Parameters:
- WIDTH, 12, bits per lane and per result.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before timeout_err is raised; must be >= 3.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  scalar element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data; transfer when in_valid && in_ready.
- vec_out  output  4*WIDTH  packed vector to the max unit; lane k = bits [(k+1)*WIDTH-1 : k*WIDTH].
- start  output  1  one-cycle request to the max unit.
- done  input  1  completion pulse from the max unit.
- max_in  input  WIDTH  max value from the max unit; sampled only when done is high in WAIT.
- result  output  WIDTH  captured max.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset values: in_ready=0, vec_out=0, start=0, result=0, result_valid=0, timeout_err=0, lane index=0, wait counter=0, state=FILL.
- Reset applies on any cycle, including mid-WAIT or HOLD. Any partial fill is discarded.
- All outputs are registered.
- in_ready is 1 from the first cycle after reset release whenever state=FILL.
- FILL:
  - On each transfer, write in_data into lane[idx], then idx++.
  - First accepted element goes to lane 0.
  - On the transfer with idx=3: idx wraps to 0, in_ready drops next cycle, go to ISSUE.
  - Gaps in in_valid are allowed; lanes already filled hold their values.
- ISSUE: lasts exactly 1 cycle. start=1, vec_out stable with all 4 lanes. Next state WAIT.
- WAIT:
  - start=0, in_ready=0, vec_out held stable.
  - The wait counter is cleared on entry and increments every WAIT cycle without done.
  - done=1: capture result<=max_in, result_valid=1 next cycle, go to HOLD.
  - No done and counter=TIMEOUT_CYCLES-1: timeout_err<=1 (sticky until reset), no result produced, go to FILL.
  - done and timeout on the same cycle: done wins; no error.
- Reference timing with a vector_max-style unit:
  - Cycle 0: 4th element accepted (edge).
  - Cycle 1: start=1.
  - Cycle 3: done=1.
  - Cycle 4: result_valid=1.
  - Cycle 5 at earliest: in_ready=1 again, if result_ready was high in cycle 4.
- HOLD:
  - result_valid=1, result held stable; in_ready=0.
  - On result_valid && result_ready: result_valid=0 and in_ready=1 next cycle, state=FILL.
- done in FILL/ISSUE/HOLD is ignored; no state or output change.
- Comparison is unsigned, and max_in is stored as-is.
- vec_out is not cleared between batches; it changes only on FILL writes.
- Wait counter width: $clog2(TIMEOUT_CYCLES).

Decomposition:
- Shared package (ee354 common pkg), contents:
  - State encoding localparams FILL=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3.
  - NUM_LANES=4, shared with vector_max.
- No sub-module needed. A single FSM plus lane register file fits comfortably.
- Bench instantiates vector_max as the downstream unit.

Test Plan:
- Basic: reset, feed 5,9,2,7 back-to-back, result_ready=1, downstream vector_max. Required:
  - vec_out lanes 0..3 = 5,9,2,7.
  - start high exactly 1 cycle, one cycle after the 4th accept.
  - result=9 with result_valid 3 cycles after start.
  - in_ready=1 one cycle later.
- Backpressure: same stream with result_ready=0 for 10 cycles. Required:
  - result_valid and result=9 held constant, in_ready=0 throughout.
  - Raise result_ready: FILL next cycle; a second batch 4095,0,1,4094 yields result=4095.
- Input gaps: in_valid toggles 1,0,0,1,0,1,1 carrying 3,x,x,8,x,1,6. Required: lanes = 3,8,1,6; single start; result=8.
- Timeout: downstream never asserts done. Required:
  - After exactly TIMEOUT_CYCLES WAIT cycles (16), timeout_err=1 and in_ready=1.
  - timeout_err stays 1 through a following good batch, which still produces a correct result.
- Boundary: done asserted on the final WAIT cycle (counter=15). Required: result captured, timeout_err=0.
- Spurious done during FILL is ignored, with no result_valid.
- Reset mid-WAIT: assert reset 1 cycle during WAIT. Required:
  - All outputs return to reset values.
  - A late done is ignored.
  - Next batch fills starting at lane 0.

Source files
------------

// File: rtl/vector_max_feeder_pkg.sv
// Shared definitions for the vector_max producer: lane count and FSM encoding.
package vector_max_feeder_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/vector_max_feeder.sv
// Packs four scalars into a vector, starts the downstream max unit, waits for done
// (with a watchdog) and presents the captured max on a valid/ready output.
module vector_max_feeder
    import vector_max_feeder_pkg::*;
#(
    parameter int WIDTH          = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_LANES*WIDTH-1:0]   vec_out,
    output logic                         start,
    input  logic                         done,
    input  logic [WIDTH-1:0]             max_in,
    output logic [WIDTH-1:0]             result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = $clog2(NUM_LANES);

    // Handshake rule on both sides: a beat moves on the rising edge where valid
    // and ready are both high; ready and valid are registered outputs here.
    state_e                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_LANES*WIDTH-1:0]   vec_q, vec_d;
    logic                         in_ready_q, in_ready_d;
    logic                         start_q, start_d;
    logic [WIDTH-1:0]             result_q, result_d;
    logic                         result_valid_q, result_valid_d;
    logic                         timeout_q, timeout_d;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        vec_d          = vec_q;
        in_ready_d     = 1'b0;
        start_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timeout_d      = timeout_q;
        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    vec_d[int'(idx_q)*WIDTH +: WIDTH] = in_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(NUM_LANES-1)) begin
                        state_d    = ISSUE;
                        in_ready_d = 1'b0;
                        start_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // done takes priority over an expiring watchdog on the same cycle
                if (done) begin
                    result_d       = max_in;
                    result_valid_d = 1'b1;
                    state_d        = HOLD;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
                    timeout_d  = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    in_ready_d     = 1'b1;
                    state_d        = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            idx_q          <= '0;
            cnt_q          <= '0;
            vec_q          <= '0;
            in_ready_q     <= 1'b0;
            start_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            vec_q          <= vec_d;
            in_ready_q     <= in_ready_d;
            start_q        <= start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign vec_out      = vec_q;
    assign start        = start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_vector_max_feeder.sv
// Bench for vector_max_feeder with a behavioural vector_max stand-in driving done/max_in.
module tb_vector_max_feeder;

    localparam int W  = 12;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic [4*W-1:0]  vec_out;
    logic            start;
    logic            done;
    logic [W-1:0]    max_in = '0;
    logic [W-1:0]    result;
    logic            result_valid;
    logic            result_ready;
    logic            timeout_err;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;

    // Downstream model controls: dm_delay = cycles from start to done, 0 = never.
    int           dm_delay = 2;
    int           dm_tmr   = 0;
    logic         dm_armed = 1'b0;
    logic         dm_done  = 1'b0;
    logic         spur     = 1'b0;
    logic [W-1:0] dm_val;

    assign done = dm_done | spur;

    vector_max_feeder #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .vec_out(vec_out), .start(start), .done(done),
        .max_in(max_in), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    always begin
        @(posedge clk);
        #1;
        dm_done = 1'b0;
        if (dm_armed) begin
            dm_tmr--;
            if (dm_tmr == 0) begin
                dm_done  = 1'b1;
                max_in   = dm_val;
                dm_armed = 1'b0;
            end
        end
        if (start && dm_delay > 0) begin
            dm_armed = 1'b1;
            dm_tmr   = dm_delay;
            dm_val   = '0;
            for (int k = 0; k < 4; k++)
                if (vec_out[k*W +: W] > dm_val) dm_val = vec_out[k*W +: W];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got=%0d exp=none", result);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_result", {52'd0, result}, {52'd0, sb_exp});
            end
        end
    end

    function automatic logic [W-1:0] ref_max(input logic [W-1:0] a, b, c, d);
        logic [W-1:0] v[4];
        int m;
        v = '{a, b, c, d};
        m = 0;
        for (int i = 0; i < 4; i++) if (int'(v[i]) > m) m = int'(v[i]);
        return W'(m);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] a, b, c, d, input bit push, input int gap);
        logic [W-1:0] v[4];
        v = '{a, b, c, d};
        if (push) exp_q.push_back(ref_max(a, b, c, d));
        for (int i = 0; i < 4; i++) begin
            repeat (gap) step();
            send(v[i]);
        end
    endtask

    task automatic wait_result(input int bound);
        int n;
        n = 0;
        while (!result_valid && n < bound) begin
            step();
            n++;
        end
        chk("result_valid_wait", {63'd0, result_valid}, 64'd1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        spur     = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [W-1:0] d0, d1, d2, d3;
        logic [W-1:0] exp_max;
    } vec_t;

    vec_t tbl[5];
    logic [W-1:0] r[4];
    logic [W-1:0] gd[7];
    bit           gv[7];

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        result_ready = 1'b1;

        // Reset values
        repeat (2) step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_vec_out", {16'd0, vec_out}, 64'd0);
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_result", {52'd0, result}, 64'd0);
        chk("rst_result_valid", {63'd0, result_valid}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic timing: 5,9,2,7 back-to-back
        feed(12'd5, 12'd9, 12'd2, 12'd7, 1'b1, 0);
        chk("basic_start", {63'd0, start}, 64'd1);
        chk("basic_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("basic_vec", {16'd0, vec_out}, {16'd0, 12'd7, 12'd2, 12'd9, 12'd5});
        step();
        chk("basic_start_one_cycle", {63'd0, start}, 64'd0);
        chk("basic_rv_c2", {63'd0, result_valid}, 64'd0);
        step();
        chk("basic_rv_c3", {63'd0, result_valid}, 64'd0);
        step();
        chk("basic_rv_c4", {63'd0, result_valid}, 64'd1);
        chk("basic_result", {52'd0, result}, 64'd9);
        step();
        chk("basic_in_ready_c5", {63'd0, in_ready}, 64'd1);
        chk("basic_rv_c5", {63'd0, result_valid}, 64'd0);

        // Table-driven batches
        tbl[0] = '{d0: 12'd1,    d1: 12'd2,    d2: 12'd3,    d3: 12'd4,    exp_max: 12'd4};
        tbl[1] = '{d0: 12'd4095, d1: 12'd0,    d2: 12'd1,    d3: 12'd4094, exp_max: 12'd4095};
        tbl[2] = '{d0: 12'd0,    d1: 12'd0,    d2: 12'd0,    d3: 12'd0,    exp_max: 12'd0};
        tbl[3] = '{d0: 12'd2048, d1: 12'd2047, d2: 12'd100,  d3: 12'd2049, exp_max: 12'd2049};
        tbl[4] = '{d0: 12'd77,   d1: 12'd77,   d2: 12'd76,   d3: 12'd3,    exp_max: 12'd77};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].exp_max);
            feed(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, 1'b0, i % 2);
            chk("tbl_vec", {16'd0, vec_out}, {16'd0, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0});
            wait_result(20);
            chk("tbl_result", {52'd0, result}, {52'd0, tbl[i].exp_max});
            step();
        end

        // Backpressure
        result_ready = 1'b0;
        feed(12'd5, 12'd9, 12'd2, 12'd7, 1'b1, 0);
        repeat (3) step();
        chk("bp_rv", {63'd0, result_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_rv", {63'd0, result_valid}, 64'd1);
            chk("bp_hold_result", {52'd0, result}, 64'd9);
            chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        result_ready = 1'b1;
        step();
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_rv", {63'd0, result_valid}, 64'd0);
        feed(12'd4095, 12'd0, 12'd1, 12'd4094, 1'b1, 0);
        wait_result(20);
        chk("bp_second_result", {52'd0, result}, 64'd4095);
        step();

        // Input gaps: valid 1,0,0,1,0,1,1 carrying 3,x,x,8,x,1,6
        gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gd = '{12'd3, 12'(4095), 12'(4000), 12'd8, 12'(3999), 12'd1, 12'd6};
        exp_q.push_back(12'd8);
        for (int i = 0; i < 7; i++) begin
            in_valid = gv[i];
            in_data  = gv[i] ? gd[i] : W'($urandom_range(0, 4095));
            step();
            if (i < 6) chk("gap_no_early_start", {63'd0, start}, 64'd0);
        end
        in_valid = 1'b0;
        chk("gap_start", {63'd0, start}, 64'd1);
        chk("gap_vec", {16'd0, vec_out}, {16'd0, 12'd6, 12'd1, 12'd8, 12'd3});
        step();
        chk("gap_single_start", {63'd0, start}, 64'd0);
        wait_result(20);
        chk("gap_result", {52'd0, result}, 64'd8);
        step();

        // Timeout: downstream never answers
        dm_delay = 0;
        feed(12'd10, 12'd20, 12'd30, 12'd40, 1'b0, 0);
        repeat (16) step();
        chk("to_err_before", {63'd0, timeout_err}, 64'd0);
        chk("to_in_ready_before", {63'd0, in_ready}, 64'd0);
        step();
        chk("to_err", {63'd0, timeout_err}, 64'd1);
        chk("to_in_ready", {63'd0, in_ready}, 64'd1);
        chk("to_no_result", {63'd0, result_valid}, 64'd0);
        dm_delay = 2;
        feed(12'd300, 12'd301, 12'd299, 12'd12, 1'b1, 0);
        wait_result(20);
        chk("to_good_result", {52'd0, result}, 64'd301);
        chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
        step();

        // Spurious done during FILL
        do_reset();
        chk("clear_err_after_reset", {63'd0, timeout_err}, 64'd0);
        exp_q.push_back(12'd900);
        send(12'd900);
        send(12'd17);
        spur = 1'b1;
        repeat (2) step();
        spur = 1'b0;
        chk("spur_no_rv", {63'd0, result_valid}, 64'd0);
        chk("spur_in_ready", {63'd0, in_ready}, 64'd1);
        send(12'd18);
        send(12'd899);
        chk("spur_vec", {16'd0, vec_out}, {16'd0, 12'd899, 12'd18, 12'd17, 12'd900});
        wait_result(20);
        step();

        // Done on the last WAIT cycle
        dm_delay = 16;
        feed(12'd1234, 12'd55, 12'd3000, 12'd2999, 1'b1, 0);
        wait_result(40);
        chk("bnd_result", {52'd0, result}, 64'd3000);
        chk("bnd_no_err", {63'd0, timeout_err}, 64'd0);
        step();
        dm_delay = 2;

        // Reset during WAIT, with a late done afterwards
        dm_delay = 5;
        feed(12'd4000, 12'd4001, 12'd4002, 12'd4003, 1'b0, 0);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_vec", {16'd0, vec_out}, 64'd0);
        chk("mid_rst_start", {63'd0, start}, 64'd0);
        chk("mid_rst_result", {52'd0, result}, 64'd0);
        chk("mid_rst_rv", {63'd0, result_valid}, 64'd0);
        chk("mid_rst_err", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;
        repeat (6) step();
        chk("late_done_ignored", {63'd0, result_valid}, 64'd0);
        dm_delay = 2;
        feed(12'd1, 12'd2, 12'd3, 12'd4, 1'b1, 0);
        chk("post_rst_lane0", {16'd0, vec_out}, {16'd0, 12'd4, 12'd3, 12'd2, 12'd1});
        wait_result(20);
        step();

        // Randomized batches with gaps and result backpressure
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 4; i++) r[i] = W'($urandom_range(0, 4095));
            result_ready = 1'b0;
            feed(r[0], r[1], r[2], r[3], 1'b1, int'($urandom_range(0, 2)));
            chk("rnd_vec", {16'd0, vec_out}, {16'd0, r[3], r[2], r[1], r[0]});
            wait_result(20);
            repeat ($urandom_range(0, 3)) step();
            result_ready = 1'b1;
            step();
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
